// File: rtl/peripheral_pwm_capture.sv
// Three-channel PWM input capture: per channel, measures high time and rising-edge period in prescaled ticks.
// Build macro PWM_CAP_FILTER_EN adds a 3-sample glitch filter behind each input synchronizer.
//
// state      | meaning
// ST_IDLE    | channel disabled, counters held at 0
// ST_ARM     | enabled, waiting for the first rising edge, no capture
// ST_MEASURE | counting period/high ticks, capture on each rising edge
module peripheral_pwm_capture #(
   parameter int PRESCALE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] d_in,
   input  logic        cs,
   input  logic [3:0]  addr,
   input  logic        rd,
   input  logic        wr,
   input  logic [2:0]  pwm_in,
   output logic [15:0] d_out
);

   typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_MEASURE} state_t;

   localparam logic [15:0] SAT        = 16'hFFFF;
   localparam logic [7:0]  PRESC_LAST = 8'(PRESCALE - 1);

   state_t      state [3];
   logic [15:0] per_cnt [3];
   logic [15:0] high_cnt [3];
   logic [15:0] cap_per [3];
   logic [15:0] cap_high [3];
   logic [15:0] per_nxt [3];
   logic [15:0] high_nxt [3];
   logic [15:0] per_start [3];
   logic [15:0] high_start [3];
   logic [2:0]  en_q, en_nxt, valid_q, ovr_q, tmo_q;
   logic [2:0]  sync1, sync2, lvl, lvl_q, rise, cap_evt, tmo_evt;
   logic [7:0]  presc_cnt;
   logic        tick, wr_ctrl, rd_status, clr;
   logic [15:0] rd_data;
   logic [11:0] ctrl_unused;

   assign ctrl_unused = d_in[14:3];
   assign wr_ctrl     = cs && wr && (addr == 4'h0);
   assign rd_status   = cs && rd && (addr == 4'h0);
   assign clr         = wr_ctrl && d_in[15];
   assign en_nxt      = wr_ctrl ? d_in[2:0] : en_q;
   assign tick        = (presc_cnt == PRESC_LAST);
   assign rise        = lvl & ~lvl_q;

`ifdef PWM_CAP_FILTER_EN
   logic [2:0] hist0, hist1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hist0 <= '0;
         hist1 <= '0;
      end else begin
         hist0 <= sync2;
         hist1 <= hist0;
      end
   end

   // lvl_q doubles as the filter state and the edge-detect flop
   always_comb begin
      lvl = lvl_q;
      for (int n = 0; n < 3; n++) begin
         if (sync2[n] == hist0[n] && hist0[n] == hist1[n])
            lvl[n] = sync2[n];
      end
   end
`else
   assign lvl = sync2;
`endif

   // The tick of the edge cycle belongs to the new period, so restarts load it rather than 0
   always_comb begin
      for (int n = 0; n < 3; n++) begin
         per_nxt[n]  = per_cnt[n];
         high_nxt[n] = high_cnt[n];
         if (tick && per_cnt[n] != SAT)
            per_nxt[n] = per_cnt[n] + 16'd1;
         if (tick && lvl[n] && high_cnt[n] != SAT)
            high_nxt[n] = high_cnt[n] + 16'd1;
         per_start[n]  = {15'd0, tick};
         high_start[n] = {15'd0, tick & lvl[n]};
         cap_evt[n] = (state[n] == ST_MEASURE) && en_nxt[n] && !clr &&
                      (rise[n] || per_nxt[n] == SAT);
         tmo_evt[n] = (state[n] == ST_MEASURE) && en_nxt[n] && !clr &&
                      !rise[n] && per_nxt[n] == SAT;
      end
   end

   always_comb begin
      case (addr)
         4'h0:    rd_data = {1'b0, en_q, lvl, tmo_q, ovr_q, valid_q};
         4'h2:    rd_data = cap_high[0];
         4'h4:    rd_data = cap_per[0];
         4'h6:    rd_data = cap_high[1];
         4'h8:    rd_data = cap_per[1];
         4'hA:    rd_data = cap_high[2];
         4'hC:    rd_data = cap_per[2];
         default: rd_data = 16'h0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         en_q      <= '0;
         sync1     <= '0;
         sync2     <= '0;
         lvl_q     <= '0;
         presc_cnt <= '0;
         valid_q   <= '0;
         ovr_q     <= '0;
         tmo_q     <= '0;
         d_out     <= '0;
         for (int n = 0; n < 3; n++) begin
            state[n]    <= ST_IDLE;
            per_cnt[n]  <= '0;
            high_cnt[n] <= '0;
            cap_per[n]  <= '0;
            cap_high[n] <= '0;
         end
      end else begin
         en_q      <= en_nxt;
         sync1     <= pwm_in;
         sync2     <= sync1;
         lvl_q     <= lvl;
         presc_cnt <= (clr || tick) ? 8'd0 : presc_cnt + 8'd1;
         if (cs && rd)
            d_out <= rd_data;

         for (int n = 0; n < 3; n++) begin
            if (clr) begin
               cap_per[n]  <= '0;
               cap_high[n] <= '0;
               valid_q[n]  <= 1'b0;
               ovr_q[n]    <= 1'b0;
               tmo_q[n]    <= 1'b0;
            end else begin
               if (cap_evt[n]) begin
                  cap_per[n]  <= rise[n] ? per_cnt[n]  : SAT;
                  cap_high[n] <= rise[n] ? high_cnt[n] : high_nxt[n];
               end
               valid_q[n] <= cap_evt[n] | (valid_q[n] & ~rd_status);
               ovr_q[n]   <= (cap_evt[n] & valid_q[n]) | (ovr_q[n] & ~rd_status);
               tmo_q[n]   <= tmo_evt[n] | (tmo_q[n] & ~rd_status);
            end

            if (clr || !en_nxt[n]) begin
               state[n]    <= ST_IDLE;
               per_cnt[n]  <= '0;
               high_cnt[n] <= '0;
            end else begin
               case (state[n])
                  ST_IDLE: begin
                     if (en_q[n])
                        state[n] <= ST_ARM;
                  end
                  ST_ARM: begin
                     if (rise[n]) begin
                        state[n]    <= ST_MEASURE;
                        per_cnt[n]  <= per_start[n];
                        high_cnt[n] <= high_start[n];
                     end
                  end
                  ST_MEASURE: begin
                     if (rise[n]) begin
                        per_cnt[n]  <= per_start[n];
                        high_cnt[n] <= high_start[n];
                     end else if (tmo_evt[n]) begin
                        state[n]    <= ST_ARM;
                        per_cnt[n]  <= '0;
                        high_cnt[n] <= '0;
                     end else begin
                        per_cnt[n]  <= per_nxt[n];
                        high_cnt[n] <= high_nxt[n];
                     end
                  end
                  default: state[n] <= ST_IDLE;
               endcase
            end
         end
      end
   end

endmodule
